// File: rtl/fpjh_pkg.sv
// fpjh_pkg: shared header format and FSM state encoding for the fpjh fragment/aggregate link
package fpjh_pkg;
  localparam logic [3:0] SYNC = 4'hA;
  localparam int HDR_SYNC_LSB = 28;
  localparam int HDR_SEQ_LSB = 20;
  localparam int HDR_FIRST = 19;
  localparam int HDR_LAST = 18;
  localparam int HDR_IDX_LSB = 12;
  localparam int HDR_CNT_LSB = 0;
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  typedef struct packed {
    logic [3:0] sync;
    logic [7:0] seq;
    logic first;
    logic last;
    logic [5:0] idx;
    logic [11:0] cnt;
  } hdr_t;
  function automatic logic [31:0] hdr_pack(input logic [7:0] seq, input logic first, input logic last,
                                           input logic [5:0] idx, input logic [11:0] cnt);
    hdr_t h;
    h = '{sync: SYNC, seq: seq, first: first, last: last, idx: idx, cnt: cnt};
    return h;
  endfunction
  function automatic hdr_t hdr_unpack(input logic [31:0] w);
    return '{sync: w[HDR_SYNC_LSB +: 4], seq: w[HDR_SEQ_LSB +: 8], first: w[HDR_FIRST],
             last: w[HDR_LAST], idx: w[HDR_IDX_LSB +: 6], cnt: w[HDR_CNT_LSB +: 12]};
  endfunction
endpackage

// File: rtl/fpjh_send_if.sv
// fpjh_send_if: 32-bit AXI-Stream bundle with byte keep
interface fpjh_send_if;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/fpjh_axis_reg.sv
// fpjh_axis_reg: single AXI-Stream output register stage, loads when empty or drained
module fpjh_axis_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [31:0] d_data,
  input  logic [3:0]  d_keep,
  input  logic        d_last,
  input  logic        ready,
  output logic        upd,
  output logic        valid,
  output logic [31:0] data,
  output logic [3:0]  keep,
  output logic        last
);
  assign upd = !valid || ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {valid, data, keep, last} <= '0;
    else if (upd) {valid, data, keep, last} <= {d_valid, d_data, d_keep, d_last};
endmodule

// File: rtl/fpjh_send.sv
// fpjh_send: splits length-tagged AXI-Stream packets into header-prefixed fragments
module fpjh_send
  import fpjh_pkg::*;
#(
  parameter int FRAG_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_length,
  fpjh_send_if.slave  i_axis,
  fpjh_send_if.master o_axis
);
  localparam logic [11:0] FRAG_BYTES = 12'(FRAG_WORDS * 4);
  localparam int WW = $clog2(FRAG_WORDS);
  state_t state, state_d;
  logic [7:0] seq, seq_d;
  logic [5:0] idx, idx_d;
  logic [11:0] rem, rem_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic upd, take, frag_end, d_valid, d_last;
  logic [31:0] d_data;
  logic [3:0] d_keep;
  assign i_axis.tready = state == PAY && upd;
  assign take = i_axis.tready && i_axis.tvalid;
  assign frag_end = wcnt == WW'(FRAG_WORDS - 1);
  always_comb begin
    state_d = state;
    seq_d = seq;
    idx_d = idx;
    rem_d = rem;
    wcnt_d = wcnt;
    d_valid = 1'b0;
    d_data = i_axis.tdata;
    d_keep = i_axis.tlast ? i_axis.tkeep : 4'hF;
    d_last = i_axis.tlast || frag_end;
    case (state)
      IDLE: if (i_axis.tvalid) begin
        state_d = HDR;
        rem_d = i_length;
        idx_d = '0;
        wcnt_d = '0;
      end
      HDR: if (upd) begin
        state_d = PAY;
        d_valid = 1'b1;
        d_data = hdr_pack(seq, idx == '0, rem <= FRAG_BYTES, idx, rem > FRAG_BYTES ? FRAG_BYTES : rem);
        d_keep = 4'hF;
        d_last = 1'b0;
      end
      PAY: if (take) begin
        d_valid = 1'b1;
        wcnt_d = WW'(wcnt + 1'b1);
        if (i_axis.tlast) begin
          state_d = IDLE;
          seq_d = seq + 8'd1;
        end else if (frag_end) begin
          // overlong packets keep fragmenting with a zero byte count
          state_d = HDR;
          idx_d = idx + 6'd1;
          rem_d = rem > FRAG_BYTES ? rem - FRAG_BYTES : '0;
          wcnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      seq <= '0;
      idx <= '0;
      rem <= '0;
      wcnt <= '0;
    end else begin
      state <= state_d;
      seq <= seq_d;
      idx <= idx_d;
      rem <= rem_d;
      wcnt <= wcnt_d;
    end
  fpjh_axis_reg u_oreg (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_data(d_data), .d_keep(d_keep), .d_last(d_last),
    .ready(o_axis.tready), .upd(upd),
    .valid(o_axis.tvalid), .data(o_axis.tdata), .keep(o_axis.tkeep), .last(o_axis.tlast)
  );
endmodule

// File: tb/tb_fpjh_send.sv
// tb_fpjh_send: scoreboard bench for fpjh_send fragmentation, stalls, reset and sequence wrap
module tb_fpjh_send;
  localparam int FW = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] i_length = '0;
  logic rnd = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int hdr_cyc = -1;
  logic [31:0] first_word = '0;
  logic [7:0] exp_seq = '0;
  logic [36:0] exp_q[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [36:0] pw = '0;
  fpjh_send_if in_if ();
  fpjh_send_if out_if ();
  fpjh_send #(.FRAG_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .i_length(i_length), .i_axis(in_if), .o_axis(out_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && out_if.tvalid && out_if.tready) begin
      if (hdr_cyc < 0) begin
        hdr_cyc <= cyc;
        first_word <= out_if.tdata;
      end
      if (exp_q.size() == 0) chk("extra_beat", {out_if.tdata, out_if.tkeep, out_if.tlast}, 0);
      else begin
        chk("beat", {out_if.tdata, out_if.tkeep, out_if.tlast}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    if (rst && pv && !pr) chk("stall_hold", {out_if.tvalid, out_if.tdata, out_if.tkeep, out_if.tlast}, {1'b1, pw});
    pv <= out_if.tvalid;
    pr <= out_if.tready;
    pw <= {out_if.tdata, out_if.tkeep, out_if.tlast};
  end
  task automatic send(input int len, input int gap);
    int nb, nf, f, cnt, to;
    logic lastb;
    logic [3:0] lk;
    nb = (len + 3) / 4;
    nf = (len + FW * 4 - 1) / (FW * 4);
    lk = (len % 4 == 1) ? 4'b1000 : (len % 4 == 2) ? 4'b1100 : (len % 4 == 3) ? 4'b1110 : 4'hF;
    i_length = 12'(len);
    for (int b = 0; b < nb; b++) begin
      if (b % FW == 0) begin
        f = b / FW;
        cnt = (f == nf - 1) ? len - f * FW * 4 : FW * 4;
        exp_q.push_back({4'hA, exp_seq, f == 0, f == nf - 1, 6'(f), 12'(cnt), 4'hF, 1'b0});
      end
      lastb = b == nb - 1;
      in_if.tdata = $urandom;
      in_if.tkeep = lastb ? lk : 4'hF;
      in_if.tlast = lastb;
      in_if.tvalid = 1'b1;
      if (b == 0) t0 = cyc;
      exp_q.push_back({in_if.tdata, in_if.tkeep, lastb || (b % FW == FW - 1)});
      to = 0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          in_if.tvalid = 1'b0;
          return;
        end
        if (b == 0 && to == 0) chk("rdy_idle", in_if.tready, 0);
        if (in_if.tready) break;
        to++;
        if (to > 5000) begin
          chk("timeout", 1, 0);
          in_if.tvalid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    in_if.tvalid = 1'b0;
    in_if.tlast = 1'b0;
    exp_seq = exp_seq + 8'd1;
    repeat (gap) @(posedge clk);
    #1;
  endtask
  initial begin
    in_if.tvalid = 1'b0;
    in_if.tlast = 1'b0;
    in_if.tdata = '0;
    in_if.tkeep = '0;
    out_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {out_if.tvalid, out_if.tlast, out_if.tdata, out_if.tkeep, in_if.tready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(120, 5);
    chk("t3_header", first_word, 32'hA00C0078);
    chk("t3_latency", hdr_cyc - t0, 2);
    send(829, 4);
    for (int p = 0; p < 3; p++) send(829, 103);
    chk("t2_drained", exp_q.size(), 0);
    rnd = 1'b1;
    send(829, 10);
    repeat (40) @(posedge clk);
    rnd = 1'b0;
    #1;
    chk("t4_drained", exp_q.size(), 0);
    fork
      send(829, 0);
      begin
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b0;
      end
    join
    repeat (2) begin
      @(negedge clk);
      chk("t5_reset_out", {out_if.tvalid, out_if.tlast, out_if.tdata, out_if.tkeep, in_if.tready}, 0);
    end
    exp_q.delete();
    exp_seq = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hdr_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    send(120, 3);
    chk("t5_fresh_hdr", first_word, 32'hA00C0078);
    for (int p = 0; p < 256; p++) send(4 * (1 + p % 3), p % 2);
    repeat (20) @(posedge clk);
    chk("t6_seq_model", exp_seq, 8'd1);
    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
